// File: rtl/vector_pkg.sv
// Shared types for the vector display path: FSM encoding, widths,
// and the command word layout used by the display-list reader.
package vector_pkg;

  localparam int W_DEF = 8;
  localparam int ERR_W = W_DEF + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2
  } state_t;

  typedef struct packed {
    logic             blank;
    logic [W_DEF-1:0] z;
    logic [W_DEF-1:0] y;
    logic [W_DEF-1:0] x;
  } vec_cmd_t;

  localparam int CMD_W = $bits(vec_cmd_t);

endpackage

// File: rtl/vector_axis_setup.sv
// Per-axis line setup: distance magnitude and step direction.
module vector_axis_setup #(
  parameter int W = 8
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] dst,
  output logic [W-1:0] mag,
  output logic         neg
);

  assign neg = dst < cur;
  assign mag = neg ? cur - dst : dst - cur;

endmodule

// File: rtl/vector_dda.sv
// Bresenham vector walker feeding X/Y/Z samples to the DAC shifter,
// one point per sample tick.
module vector_dda
  import vector_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int DOT_DWELL = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         sample_tick,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_x,
  input  logic [W-1:0] cmd_y,
  input  logic [W-1:0] cmd_z,
  input  logic         cmd_blank,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out,
  output logic [W-1:0] z_out,
  output logic         busy,
  output logic         vec_done
);

  localparam int EW    = W + 2;
  localparam int DWELL = (DOT_DWELL < 1) ? 1 : DOT_DWELL;
  localparam int CW    = $clog2(DWELL + 1);

  state_t               state;
  logic [W-1:0]         x, y, x1, y1;
  logic [W-1:0]         z_eff, dx, dy;
  logic                 sx_neg, sy_neg, dot;
  logic signed [EW-1:0] err, err_n;
  logic [CW-1:0]        dwell;

  logic [W-1:0]         adx, ady;
  logic                 nx, ny;
  logic signed [EW:0]   e2, ndy, pdx;
  logic                 step_x, step_y;
  logic                 at_end, accept;

  vector_axis_setup #(.W(W)) u_ax (
    .cur (x),
    .dst (x1),
    .mag (adx),
    .neg (nx)
  );

  vector_axis_setup #(.W(W)) u_ay (
    .cur (y),
    .dst (y1),
    .mag (ady),
    .neg (ny)
  );

  assign accept = cmd_valid && cmd_ready;
  assign busy   = (state != IDLE);
  assign at_end = (x == x1) && (y == y1);

  assign e2     = $signed({err, 1'b0});
  assign ndy    = -$signed({3'b000, dy});
  assign pdx    = $signed({3'b000, dx});
  assign step_x = e2 >= ndy;
  assign step_y = e2 <= pdx;

  // both axis decisions use the pre-update error term
  always_comb begin
    err_n = err;
    if (step_x) err_n = err_n - $signed({2'b00, dy});
    if (step_y) err_n = err_n + $signed({2'b00, dx});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      x1        <= '0;
      y1        <= '0;
      z_eff     <= '0;
      dx        <= '0;
      dy        <= '0;
      sx_neg    <= 1'b0;
      sy_neg    <= 1'b0;
      dot       <= 1'b0;
      err       <= '0;
      dwell     <= '0;
      cmd_ready <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
      vec_done  <= 1'b0;
    end else begin
      vec_done <= 1'b0;
      unique case (state)
        IDLE: begin
          cmd_ready <= !accept;
          if (sample_tick) z_out <= '0;
          if (accept) begin
            x1    <= cmd_x;
            y1    <= cmd_y;
            z_eff <= cmd_blank ? '0 : cmd_z;
            state <= SETUP;
          end
        end
        SETUP: begin
          dx     <= adx;
          dy     <= ady;
          sx_neg <= nx;
          sy_neg <= ny;
          err    <= $signed({2'b00, adx}) - $signed({2'b00, ady});
          dot    <= (adx == '0) && (ady == '0);
          dwell  <= CW'(DWELL);
          state  <= DRAW;
        end
        DRAW: begin
          if (sample_tick) begin
            x_out <= x;
            y_out <= y;
            z_out <= z_eff;
            if (dot) begin
              if (dwell <= CW'(1)) begin
                state    <= IDLE;
                vec_done <= 1'b1;
              end else begin
                dwell <= dwell - 1'b1;
              end
            end else if (at_end) begin
              state    <= IDLE;
              vec_done <= 1'b1;
            end else begin
              if (step_x) x <= sx_neg ? x - 1'b1 : x + 1'b1;
              if (step_y) y <= sy_neg ? y - 1'b1 : y + 1'b1;
              err <= err_n;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_dda.sv
// Directed bench for vector_dda with a sample scoreboard.
module tb_vector_dda;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sample_tick = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_x = '0, cmd_y = '0, cmd_z = '0;
  logic       cmd_blank = 1'b0;
  logic [7:0] x_out, y_out, z_out;
  logic       busy, vec_done;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [23:0] exp_q[$];
  int         px = 0, py = 0;
  longint     last_tick = 0, vd_time = 0, acc_time = 0;
  int         vd_cnt = 0;

  vector_dda #(.W(8), .DOT_DWELL(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_tick (sample_tick),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_z       (cmd_z),
    .cmd_blank   (cmd_blank),
    .x_out       (x_out),
    .y_out       (y_out),
    .z_out       (z_out),
    .busy        (busy),
    .vec_done    (vec_done)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (15) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int x, input int y, input int z);
    exp_q.push_back({8'(x), 8'(y), 8'(z)});
  endtask

  // reference line walk from the bench's tracked beam position
  task automatic model(input int x1, input int y1, input int z,
                       input bit blank);
    int x, y, dx, dy, sx, sy, err, e2, zz, n;
    x  = px;
    y  = py;
    zz = blank ? 0 : z;
    dx = (x1 > x) ? x1 - x : x - x1;
    dy = (y1 > y) ? y1 - y : y - y1;
    sx = (x1 < x) ? -1 : 1;
    sy = (y1 < y) ? -1 : 1;
    err = dx - dy;
    if (dx == 0 && dy == 0) begin
      repeat (4) push(x, y, zz);
    end else begin
      for (n = 0; n < 600; n++) begin
        push(x, y, zz);
        if (x == x1 && y == y1) break;
        e2 = 2 * err;
        if (e2 >= -dy) begin err -= dy; x += sx; end
        if (e2 <= dx)  begin err += dx; y += sy; end
      end
    end
    px = x1;
    py = y1;
  endtask

  always @(posedge clk) begin
    logic tk, bz;
    logic [23:0] e;
    tk = sample_tick;
    bz = busy;
    if (tk) last_tick = $time;
    #1;
    if (vec_done) begin
      vd_cnt++;
      vd_time = $time - 1;
    end
    if (tk && bz) begin
      if (exp_q.size() == 0) begin
        chk("sample_unexpected", {8'h0, x_out, y_out, z_out}, 32'hFFFFFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sample", {8'h0, x_out, y_out, z_out}, {8'h0, e});
      end
    end
  end

  always @(negedge clk)
    if (reset_n) chk("ready_while_busy", 32'(cmd_ready && busy), 0);

  task automatic wait_tick();
    int i;
    for (i = 0; i < 100; i++) begin
      @(posedge clk);
      if (sample_tick) break;
    end
    chk("tick_timeout", 32'(i < 100), 1);
  endtask

  task automatic send(input int x, input int y, input int z,
                      input bit b);
    int i;
    wait_tick();
    @(negedge clk);
    cmd_x = 8'(x);
    cmd_y = 8'(y);
    cmd_z = 8'(z);
    cmd_blank = b;
    cmd_valid = 1'b1;
    for (i = 0; i < 200; i++) begin
      @(posedge clk);
      if (cmd_ready) begin
        acc_time = $time;
        break;
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("accept_timeout", 32'(i < 200), 1);
  endtask

  task automatic wait_done(input string tag);
    int i;
    bit seen;
    seen = 0;
    for (i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (vec_done) begin
        seen = 1;
        break;
      end
    end
    chk(tag, 32'(seen), 1);
  endtask

  initial begin
    int i, vd0;
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int vd0, i;
    bit ok;
    #23;
    chk("rst_x", 32'(x_out), 0);
    chk("rst_y", 32'(y_out), 0);
    chk("rst_z", 32'(z_out), 0);
    chk("rst_ready", 32'(cmd_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(vec_done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", 32'(cmd_ready), 1);

    push(0, 0, 8'h80);
    push(1, 1, 8'h80);
    push(2, 1, 8'h80);
    push(3, 2, 8'h80);
    push(4, 2, 8'h80);
    px = 4;
    py = 2;
    send(4, 2, 8'h80, 0);
    wait_done("v1_done");
    chk("v1_done_after_tick", 32'(vd_time - last_tick), 0);
    chk("v1_q_empty", exp_q.size(), 0);
    wait_tick();
    #1;
    chk("idle_tick_z", 32'(z_out), 0);
    chk("idle_tick_xy", {16'h0, x_out, y_out}, 32'h0402);

    model(0, 2, 8'hFF, 1);
    send(0, 2, 8'hFF, 1);
    wait_done("blank_done");
    chk("blank_busy_low", 32'(busy), 0);
    chk("blank_q_empty", exp_q.size(), 0);

    model(0, 2, 8'h40, 0);
    send(0, 2, 8'h40, 0);
    wait_done("dot_done");
    chk("dot_q_empty", exp_q.size(), 0);

    model(0, 0, 8'h10, 0);
    send(0, 0, 8'h10, 0);
    wait_done("home_done");
    model(255, 0, 8'h20, 0);
    send(255, 0, 8'h20, 0);
    wait_done("wide_done");
    chk("wide_q_empty", exp_q.size(), 0);
    model(250, 255, 8'h30, 0);
    send(250, 255, 8'h30, 0);
    wait_done("steep_done");
    chk("steep_q_empty", exp_q.size(), 0);
    chk("steep_end", {16'h0, x_out, y_out}, 32'hFAFF);

    model(252, 250, 8'h11, 0);
    model(252, 250, 8'h22, 0);
    model(240, 245, 8'h33, 0);
    wait_tick();
    @(negedge clk);
    cmd_x = 8'd252; cmd_y = 8'd250; cmd_z = 8'h11; cmd_blank = 0;
    cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ok = 0;
      for (i = 0; i < 200; i++) begin
        @(posedge clk);
        if (cmd_ready) begin
          ok = 1;
          acc_time = $time;
          break;
        end
      end
      chk("b2b_accept", 32'(ok), 1);
      if (k > 0) chk("b2b_gap", 32'(acc_time - vd_time), 20);
      #1;
      if (k == 0) cmd_z = 8'h22;
      if (k == 1) begin cmd_x = 8'd240; cmd_y = 8'd245; cmd_z = 8'h33; end
      if (k == 2) cmd_valid = 1'b0;
      wait_done("b2b_done");
    end
    chk("b2b_q_empty", exp_q.size(), 0);

    model(100, 50, 8'h77, 0);
    send(100, 50, 8'h77, 0);
    repeat (3) wait_tick();
    @(posedge clk);
    #3;
    vd0 = vd_cnt;
    reset_n = 1'b0;
    #1;
    chk("arst_x", 32'(x_out), 0);
    chk("arst_y", 32'(y_out), 0);
    chk("arst_z", 32'(z_out), 0);
    chk("arst_ready", 32'(cmd_ready), 0);
    chk("arst_busy", 32'(busy), 0);
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("arst_ready_hold", 32'(cmd_ready), 0);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 1);
    chk("no_done_on_rst", vd_cnt, vd0);
    px = 0;
    py = 0;
    model(3, 1, 8'h55, 0);
    send(3, 1, 8'h55, 0);
    wait_done("post_rst_done");
    chk("post_rst_q_empty", exp_q.size(), 0);
    chk("post_rst_end", {8'h0, x_out, y_out, z_out}, 32'h030155);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
